vc_flit_fifo: RTL and testbench

//  Multi-channel flit buffer for the collective router, next generation of the single-queue port FIFO.

---
 rtl/vc_flit_fifo.sv | 159 +++++++++++++++
 tb/tb_vc_flit_fifo.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_flit_fifo.sv
// vc_flit_fifo: multi-VC flit buffer. NUM_VC FIFO queues share one memory.
// Incoming flits whose valid bit is clear are dropped. Non-empty VCs are
// round-robined onto a single registered valid/ready output stage.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   wr_en/wr_vc/wr_data    write strobe, target VC, flit to store
//   full/afull/empty       per-VC status, decoded from the registered counts
//   vc_count               packed per-VC counts, LG_DEPTH+1 bits each
//   out_valid/out_data/out_vc/out_ready   registered output handshake
//   ovf_err                sticky flag: a write was attempted to a full VC
module vc_flit_fifo #(
  parameter int unsigned FLIT_W    = 85,
  parameter int unsigned VALID_POS = 81,
  parameter int unsigned LG_VC     = 1,
  parameter int unsigned LG_DEPTH  = 4,
  parameter int unsigned AFULL_TH  = (1 << LG_DEPTH) - 2,
  localparam int unsigned NUM_VC   = 1 << LG_VC,
  localparam int unsigned DEPTH    = 1 << LG_DEPTH,
  localparam int unsigned CW       = LG_DEPTH + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [LG_VC-1:0]     wr_vc,
  input  logic [FLIT_W-1:0]    wr_data,
  output logic [NUM_VC-1:0]    full,
  output logic [NUM_VC-1:0]    afull,
  output logic [NUM_VC-1:0]    empty,
  output logic [NUM_VC*CW-1:0] vc_count,
  output logic                 out_valid,
  output logic [FLIT_W-1:0]    out_data,
  output logic [LG_VC-1:0]     out_vc,
  input  logic                 out_ready,
  output logic                 ovf_err
);

  logic [FLIT_W-1:0]   mem_q [NUM_VC*DEPTH];
  logic [LG_DEPTH-1:0] wr_ptr_q [NUM_VC];
  logic [LG_DEPTH-1:0] wr_ptr_d [NUM_VC];
  logic [LG_DEPTH-1:0] rd_ptr_q [NUM_VC];
  logic [LG_DEPTH-1:0] rd_ptr_d [NUM_VC];
  logic [CW-1:0]       cnt_q [NUM_VC];
  logic [CW-1:0]       cnt_d [NUM_VC];

  logic [LG_VC-1:0]  last_q, last_d;
  logic              out_valid_q, out_valid_d;
  logic [FLIT_W-1:0] out_data_q, out_data_d;
  logic [LG_VC-1:0]  out_vc_q, out_vc_d;
  logic              ovf_q, ovf_d;

  logic              push, wr_drop, load, pop, grant_found;
  logic [LG_VC-1:0]  grant_vc, cand;
  logic [FLIT_W-1:0] head_data;

  // Status flags are pure decodes of the registered counts.
  always_comb begin
    full     = '0;
    afull    = '0;
    empty    = '0;
    vc_count = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      full[v]              = (cnt_q[v] == CW'(DEPTH));
      afull[v]             = (cnt_q[v] >= CW'(AFULL_TH));
      empty[v]             = (cnt_q[v] == '0);
      vc_count[v*CW +: CW] = cnt_q[v];
    end
  end

  // Round-robin: first non-empty VC after the last grant, cyclically.
  always_comb begin
    grant_found = 1'b0;
    grant_vc    = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_VC; i++) begin
      cand = last_q + LG_VC'(i);
      if (!grant_found && !empty[cand]) begin
        grant_found = 1'b1;
        grant_vc    = cand;
      end
    end
  end

  assign push      = wr_en && wr_data[VALID_POS] && !full[wr_vc];
  assign wr_drop   = wr_en && wr_data[VALID_POS] && full[wr_vc];
  assign load      = !out_valid_q || out_ready;
  assign pop       = load && grant_found;
  assign head_data = mem_q[{grant_vc, rd_ptr_q[grant_vc]}];

  // Next-state for pointers, counts and the output stage.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_vc_d    = out_vc_q;
    last_d      = last_q;
    ovf_d       = ovf_q | wr_drop;
    for (int v = 0; v < NUM_VC; v++) begin
      wr_ptr_d[v] = wr_ptr_q[v];
      rd_ptr_d[v] = rd_ptr_q[v];
      cnt_d[v]    = cnt_q[v];
      if (push && (wr_vc == LG_VC'(v))) begin
        wr_ptr_d[v] = wr_ptr_q[v] + 1'b1;
      end
      if (pop && (grant_vc == LG_VC'(v))) begin
        rd_ptr_d[v] = rd_ptr_q[v] + 1'b1;
      end
      // Simultaneous push and pop on one VC leaves its count unchanged.
      cnt_d[v] = cnt_q[v] + CW'(push && (wr_vc == LG_VC'(v)))
                          - CW'(pop && (grant_vc == LG_VC'(v)));
    end
    if (load) begin
      out_valid_d = grant_found;
    end
    if (pop) begin
      out_data_d = head_data;
      out_vc_d   = grant_vc;
      last_d     = grant_vc;
    end
  end

  // Control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        cnt_q[v]    <= '0;
      end
      last_q      <= LG_VC'(NUM_VC - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_vc_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= wr_ptr_d[v];
        rd_ptr_q[v] <= rd_ptr_d[v];
        cnt_q[v]    <= cnt_d[v];
      end
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_vc_q    <= out_vc_d;
      ovf_q       <= ovf_d;
    end
  end

  // Shared flit storage; left unreset because empty slots are never read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[{wr_vc, wr_ptr_q[wr_vc]}] <= wr_data;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_vc    = out_vc_q;
  assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_vc_flit_fifo.sv
// tb_vc_flit_fifo: scoreboard bench for vc_flit_fifo. A queue-based
// reference model tracks per-VC occupancy and the output register; a
// negedge monitor compares status every cycle and pops expected flits on
// each output handshake.
module tb_vc_flit_fifo;
  localparam int FW  = 85;
  localparam int VP  = 81;
  localparam int LGV = 1;
  localparam int LGD = 4;
  localparam int NV  = 2;
  localparam int D   = 16;
  localparam int CW  = 5;
  localparam int ATH = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [LGV-1:0]    wr_vc;
  logic [FW-1:0]     wr_data;
  logic [NV-1:0]     full, afull, empty;
  logic [NV*CW-1:0]  vc_count;
  logic              out_valid;
  logic [FW-1:0]     out_data;
  logic [LGV-1:0]    out_vc;
  logic              out_ready;
  logic              ovf_err;

  vc_flit_fifo dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_vc(wr_vc), .wr_data(wr_data),
    .full(full), .afull(afull), .empty(empty), .vc_count(vc_count),
    .out_valid(out_valid), .out_data(out_data), .out_vc(out_vc),
    .out_ready(out_ready), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Reference model state.
  int            mcnt [NV];
  bit            mov;
  int            mvc;
  int            mlast;
  bit            movf;
  logic [FW-1:0] sb [NV][$];
  int            hs_log [$];
  bit            m_acc, m_drop, m_ld;
  int            m_g;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] mkflit(input bit v);
    logic [95:0] r;
    logic [FW-1:0] d;
    r = {$urandom, $urandom, $urandom};
    d = r[FW-1:0];
    d[VP] = v;
    return d;
  endfunction

  // Model update: FIFO semantics per VC, one output register, rr grant.
  always @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NV; v++) begin
        mcnt[v] = 0;
        sb[v].delete();
      end
      mov = 1'b0; mvc = 0; mlast = NV - 1; movf = 1'b0;
    end else begin
      m_acc  = wr_en && wr_data[VP] && (mcnt[wr_vc] < D);
      m_drop = wr_en && wr_data[VP] && (mcnt[wr_vc] >= D);
      m_ld   = !mov || out_ready;
      if (m_ld) begin
        m_g = -1;
        for (int k = 1; k <= NV; k++)
          if (m_g < 0 && mcnt[(mlast + k) % NV] > 0) m_g = (mlast + k) % NV;
        if (m_g >= 0) begin
          mcnt[m_g]--; mov = 1'b1; mvc = m_g; mlast = m_g;
        end else begin
          mov = 1'b0;
        end
      end
      if (m_acc) begin
        mcnt[wr_vc]++;
        sb[wr_vc].push_back(wr_data);
      end
      if (m_drop) movf = 1'b1;
    end
  end

  // Monitor: status every cycle, data on each handshake.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int v = 0; v < NV; v++) begin
        chk($sformatf("count[%0d]", v), vc_count[v*CW +: CW], mcnt[v]);
        chk($sformatf("full[%0d]", v),  full[v],  mcnt[v] == D);
        chk($sformatf("afull[%0d]", v), afull[v], mcnt[v] >= ATH);
        chk($sformatf("empty[%0d]", v), empty[v], mcnt[v] == 0);
      end
      chk("out_valid", out_valid, mov);
      chk("ovf_err", ovf_err, movf);
      if (mov) chk("out_vc", out_vc, mvc);
      if (out_valid && out_ready) begin
        hs_log.push_back(int'(out_vc));
        if (sb[out_vc].size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL out_data: got %0h with no flit expected on vc %0d", out_data, out_vc);
        end else begin
          chk("out_data", out_data, sb[out_vc].pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    wr_en = 1'b0; rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic rand_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      wr_en     = ($urandom % 4) != 0;
      wr_vc     = LGV'($urandom % NV);
      wr_data   = mkflit(($urandom % 8) != 0);
      out_ready = ($urandom % 3) != 0;
      step();
    end
    wr_en = 1'b0;
  endtask

  int hs0;
  int wrote;
  int guard;

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_vc = '0; wr_data = '0; out_ready = 1'b0;
    step(); step();
    chk_en = 1'b1;
    rst = 1'b0;

    // T1: reset in the middle of traffic
    rand_traffic(60);
    wr_en = 1'b1; wr_vc = 1'b0; wr_data = mkflit(1'b1);
    rst = 1'b1;
    step(); step();
    wr_en = 1'b0; rst = 1'b0;
    chk("t1_out_valid", out_valid, 1'b0);
    chk("t1_out_data", out_data, '0);
    chk("t1_out_vc", out_vc, '0);
    chk("t1_ovf", ovf_err, 1'b0);
    chk("t1_empty", empty, 2'b11);
    chk("t1_counts", vc_count, '0);

    // T3: write with clear valid bit is ignored
    out_ready = 1'b0;
    wr_en = 1'b1; wr_vc = 1'b0; wr_data = mkflit(1'b0);
    step();
    wr_en = 1'b0;
    step();
    chk("t3_count0", vc_count[CW-1:0], 5'd0);
    chk("t3_out_valid", out_valid, 1'b0);
    chk("t3_ovf", ovf_err, 1'b0);

    // T2: single flit latency
    out_ready = 1'b1;
    wr_en = 1'b1; wr_vc = 1'b1; wr_data = mkflit(1'b1);
    step();
    wr_en = 1'b0;
    chk("t2_not_yet_valid", out_valid, 1'b0);
    chk("t2_count1_n", vc_count[2*CW-1:CW], 5'd1);
    step();
    chk("t2_out_valid", out_valid, 1'b1);
    chk("t2_out_vc", out_vc, 1'b1);
    chk("t2_count1", vc_count[2*CW-1:CW], 5'd0);
    step();
    chk("t2_drained", out_valid, 1'b0);

    // T4: fill VC0 past full with output blocked, then drain
    pulse_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      wr_en = 1'b1; wr_vc = 1'b0; wr_data = mkflit(1'b1);
      step();
      if (i == 13) chk("t4_afull_13", afull[0], 1'b0);
      if (i == 14) chk("t4_afull_14", afull[0], 1'b1);
      if (i == 15) chk("t4_full_15", full[0], 1'b0);
      if (i == 16) begin
        chk("t4_full_16", full[0], 1'b1);
        chk("t4_ovf_before", ovf_err, 1'b0);
      end
    end
    wr_en = 1'b0;
    chk("t4_ovf", ovf_err, 1'b1);
    chk("t4_count0", vc_count[CW-1:0], 5'd16);
    hs0 = hs_log.size();
    out_ready = 1'b1;
    for (int i = 0; i < 22; i++) step();
    chk("t4_drain_count", hs_log.size() - hs0, 17);

    // T5: round-robin fairness between two loaded VCs
    pulse_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_vc = LGV'(i % 2); wr_data = mkflit(1'b1);
      step();
    end
    wr_en = 1'b0;
    hs_log.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("t5_len", hs_log.size(), 8);
    for (int i = 0; i < 8 && i < hs_log.size(); i++)
      chk($sformatf("t5_vc%0d", i), hs_log[i], i % 2);

    // T6: 40 flits through VC1 with random backpressure (pointer wrap)
    hs0 = hs_log.size();
    wrote = 0;
    guard = 0;
    while (wrote < 40 && guard < 2000) begin
      out_ready = $urandom % 2;
      wr_en = (mcnt[1] < D) && ($urandom % 4 != 0);
      wr_vc = 1'b1; wr_data = mkflit(1'b1);
      if (wr_en) wrote++;
      step();
      guard++;
    end
    wr_en = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 25; i++) step();
    chk("t6_written", wrote, 40);
    chk("t6_delivered", hs_log.size() - hs0, 40);

    // Mixed random traffic, overflow and drops included
    rand_traffic(400);

    // Final drain, bounded
    out_ready = 1'b1;
    guard = 0;
    while ((mov || mcnt[0] != 0 || mcnt[1] != 0) && guard < 200) begin
      step();
      guard++;
    end
    chk("final_drain_timeout", guard < 200, 1'b1);
    step();
    chk("final_sb0_empty", sb[0].size(), 0);
    chk("final_sb1_empty", sb[1].size(), 0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
